// File: rtl/mesh_term_rx_pkg.sv
// Shared types and header-field geometry for the mesh terminal receiver.
package mesh_term_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      POP    = 2'd1,
      SETTLE = 2'd2
   } state_t;

   localparam logic [7:0] BDCST_DEFAULT = 8'hFF;

   // Header layout, MSB first: Nxtjp[8] | row[4] | col[4] | mode[1] | payload
   function automatic int nxtjp_lsb(input int sz);
      return sz - 8;
   endfunction

   function automatic int row_lsb(input int sz);
      return sz - 12;
   endfunction

   function automatic int col_lsb(input int sz);
      return sz - 16;
   endfunction

   function automatic int mode_bit(input int sz);
      return sz - 17;
   endfunction

endpackage

// File: rtl/mesh_term_rx_if.sv
// Mesh output-port and consumer-side signals of the terminal receiver.
interface mesh_term_rx_if #(
   parameter int PCKG_SZ = 40
);
   logic               pndng;
   logic [PCKG_SZ-1:0] data_out;
   logic               pop;
   logic               rx_valid;
   logic               rx_ready;
   logic [PCKG_SZ-18:0] rx_payload;
   logic               rx_mode;
   logic [15:0]        pkt_cnt;
   logic [7:0]         err_cnt;

   // Terminal side: consumes the mesh port, produces received packets.
   modport master (
      input  pndng, data_out, rx_ready,
      output pop, rx_valid, rx_payload, rx_mode, pkt_cnt, err_cnt
   );

   // Environment side: mesh port model and packet consumer.
   modport slave (
      output pndng, data_out, rx_ready,
      input  pop, rx_valid, rx_payload, rx_mode, pkt_cnt, err_cnt
   );
endinterface

// File: rtl/mesh_term_rx_fifo.sv
// Synchronous receive FIFO; pointers carry an extra MSB for full/empty.
module term_rx_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_we;
   logic             w_re;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_we    = i_wr & ~o_full;
   assign w_re    = i_rd & ~o_empty;
   assign o_rdata = r_mem[r_rptr[AW-1:0]];

   // Pointer advance; write and read may occur in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_we) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_re) r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   // Storage array, no reset needed since empty flag gates the head.
   always_ff @(posedge i_clk) begin
      if (w_we) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/mesh_term_rx.sv
// Mesh terminal receiver: pops the mesh port, filters by address, buffers.
module mesh_term_rx
   import mesh_term_pkg::*;
#(
   parameter int         PCKG_SZ    = 40,
   parameter int         FIFO_DEPTH = 4,
   parameter int         ROW_ID     = 0,
   parameter int         COL_ID     = 0,
   parameter logic [7:0] BDCST      = BDCST_DEFAULT
) (
   input logic              clk,
   input logic              reset,
   mesh_term_rx_if.master   bus
);
   localparam int         W       = PCKG_SZ - 16;
   localparam int         NXT_LSB = nxtjp_lsb(PCKG_SZ);
   localparam int         ROW_LSB = row_lsb(PCKG_SZ);
   localparam int         COL_LSB = col_lsb(PCKG_SZ);
   localparam int         MODE_B  = mode_bit(PCKG_SZ);
   localparam logic [3:0] LP_ROW  = 4'(ROW_ID);
   localparam logic [3:0] LP_COL  = 4'(COL_ID);

   state_t         r_state;
   state_t         w_next;
   logic           w_pop;
   logic           w_accept;
   logic           w_full;
   logic           w_empty;
   logic           w_wr;
   logic           w_rd;
   logic [W-1:0]   w_rdata;
   logic [15:0]    r_pkt_cnt;
   logic [7:0]     r_err_cnt;

   assign w_accept = ((bus.data_out[ROW_LSB +: 4] == LP_ROW) &&
                      (bus.data_out[COL_LSB +: 4] == LP_COL)) ||
                     (bus.data_out[NXT_LSB +: 8] == BDCST);
   assign w_wr = w_pop & w_accept;
   assign w_rd = bus.rx_ready & ~w_empty;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next state and pop; full is checked only in IDLE so a POP write never overflows.
   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      unique case (r_state)
         IDLE:    if (bus.pndng && !w_full) w_next = POP;
         POP: begin
            w_pop  = 1'b1;
            w_next = SETTLE;
         end
         SETTLE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Saturating accepted/misrouted counters, updated at the end of POP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pkt_cnt <= '0;
         r_err_cnt <= '0;
      end else if (w_pop) begin
         if (w_accept) begin
            if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + 16'd1;
         end else begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   term_rx_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_wr    (w_wr),
      .i_wdata (bus.data_out[MODE_B:0]),
      .i_rd    (w_rd),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.pop        = w_pop;
   assign bus.rx_valid   = ~w_empty;
   assign bus.rx_mode    = w_rdata[W-1];
   assign bus.rx_payload = w_rdata[W-2:0];
   assign bus.pkt_cnt    = r_pkt_cnt;
   assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_mesh_term_rx.sv
// Directed bench for mesh_term_rx with a queue-based mesh output-port model.
module tb_mesh_term_rx;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   total_pops;
   logic [39:0] mq[$];

   mesh_term_rx_if #(.PCKG_SZ(40)) bus();

   mesh_term_rx #(
      .PCKG_SZ    (40),
      .FIFO_DEPTH (4),
      .ROW_ID     (0),
      .COL_ID     (2),
      .BDCST      (8'hFF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mesh port: head removed on a pop edge.
   always @(posedge clk) begin
      if (bus.pop === 1'b1 && mq.size() != 0) begin
         void'(mq.pop_front());
         total_pops = total_pops + 1;
      end
   end

   // Mesh port head presented shortly after each edge (FWFT).
   initial begin
      bus.pndng    = 1'b0;
      bus.data_out = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.pndng    = (mq.size() != 0);
         bus.data_out = (mq.size() != 0) ? mq[0] : 40'h0;
      end
   end

   function automatic logic [39:0] mk(input logic [7:0] n, input logic [3:0] r,
                                      input logic [3:0] c, input logic m,
                                      input logic [22:0] p);
      return {n, r, c, m, p};
   endfunction

   task automatic wait_pop(input int max, output int cycles, output bit ok);
      cycles = 0;
      ok = 1'b0;
      while (cycles < max) begin
         @(negedge clk);
         cycles++;
         if (bus.pop === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      bus.rx_ready = 1'b0;
      mq.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (bus.pop !== 1'b0 || bus.rx_valid !== 1'b0 || bus.pkt_cnt !== 16'd0 || bus.err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: pop=%b rx_valid=%b pkt=%0d err=%0d, required 0 0 0 0",
                  bus.pop, bus.rx_valid, bus.pkt_cnt, bus.err_cnt);
      end
   endtask

   task automatic test_accept();
      int cyc; bit ok;
      apply_reset();
      bus.rx_ready = 1'b1;
      mq.push_back(mk(8'h00, 4'h0, 4'h2, 1'b1, 23'h1));
      wait_pop(10, cyc, ok);
      checks++;
      if (!ok || cyc != 2) begin
         errors++;
         $display("FAIL accept_pop_latency: ok=%0d cycles=%0d, required 1 2", ok, cyc);
      end
      @(negedge clk);
      checks++;
      if (bus.pop !== 1'b0 || bus.rx_valid !== 1'b1 || bus.rx_payload !== 23'h1 ||
          bus.rx_mode !== 1'b1 || bus.pkt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL accept_data: pop=%b valid=%b payload=%h mode=%b pkt=%0d, required 0 1 000001 1 1",
                  bus.pop, bus.rx_valid, bus.rx_payload, bus.rx_mode, bus.pkt_cnt);
      end
      @(negedge clk);
      checks++;
      if (bus.rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL accept_drain: rx_valid=%b, required 0", bus.rx_valid);
      end
   endtask

   task automatic test_reject();
      int cyc; bit ok;
      apply_reset();
      bus.rx_ready = 1'b1;
      mq.push_back(mk(8'h00, 4'h1, 4'h3, 1'b0, 23'h55));
      wait_pop(10, cyc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reject_pop: no pop seen within 10 cycles, required a pop");
      end
      @(negedge clk);
      checks++;
      if (bus.rx_valid !== 1'b0 || bus.err_cnt !== 8'd1 || bus.pkt_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reject_counts: valid=%b err=%0d pkt=%0d, required 0 1 0",
                  bus.rx_valid, bus.err_cnt, bus.pkt_cnt);
      end
   endtask

   task automatic test_broadcast();
      int cyc; bit ok;
      apply_reset();
      mq.push_back(mk(8'hFF, 4'h3, 4'h3, 1'b0, 23'hAA));
      wait_pop(10, cyc, ok);
      @(negedge clk);
      checks++;
      if (!ok || bus.rx_valid !== 1'b1 || bus.rx_payload !== 23'hAA || bus.rx_mode !== 1'b0 ||
          bus.pkt_cnt !== 16'd1 || bus.err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL broadcast: popped=%0d valid=%b payload=%h mode=%b pkt=%0d err=%0d, required 1 1 0000aa 0 1 0",
                  ok, bus.rx_valid, bus.rx_payload, bus.rx_mode, bus.pkt_cnt, bus.err_cnt);
      end
      bus.rx_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL broadcast_drain: rx_valid=%b, required 0", bus.rx_valid);
      end
   endtask

   task automatic test_backpressure();
      int base; int got; logic [22:0] seen[$];
      apply_reset();
      base = total_pops;
      for (int i = 0; i < 6; i++) mq.push_back(mk(8'h00, 4'h0, 4'h2, 1'b0, 23'h10 + 23'(i)));
      repeat (30) @(negedge clk);
      checks++;
      if (total_pops - base != 4 || bus.pndng !== 1'b1 || bus.pop !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_hold: pops=%0d pndng=%b pop=%b, required 4 1 0",
                  total_pops - base, bus.pndng, bus.pop);
      end
      checks++;
      if (bus.rx_valid !== 1'b1 || bus.rx_payload !== 23'h10) begin
         errors++;
         $display("FAIL backpressure_head: valid=%b payload=%h, required 1 000010",
                  bus.rx_valid, bus.rx_payload);
      end
      bus.rx_ready = 1'b1;
      for (int c = 0; c < 40 && seen.size() < 6; c++) begin
         if (bus.rx_valid === 1'b1) seen.push_back(bus.rx_payload);
         @(negedge clk);
      end
      got = seen.size();
      checks++;
      if (got != 6 || total_pops - base != 6 || bus.pkt_cnt !== 16'd6) begin
         errors++;
         $display("FAIL backpressure_drain: received=%0d pops=%0d pkt=%0d, required 6 6 6",
                  got, total_pops - base, bus.pkt_cnt);
      end
      for (int i = 0; i < got; i++) begin
         checks++;
         if (seen[i] !== 23'h10 + 23'(i)) begin
            errors++;
            $display("FAIL backpressure_order[%0d]: payload=%h, required %h", i, seen[i], 23'h10 + 23'(i));
         end
      end
   endtask

   task automatic test_reset_in_pop();
      int cyc; bit ok;
      apply_reset();
      mq.push_back(mk(8'h00, 4'h0, 4'h2, 1'b1, 23'h77));
      wait_pop(10, cyc, ok);
      #1 reset = 1'b0;
      #1;
      checks++;
      if (!ok || bus.pop !== 1'b0 || bus.rx_valid !== 1'b0 || bus.pkt_cnt !== 16'd0 || bus.err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_in_pop: popped=%0d pop=%b valid=%b pkt=%0d err=%0d, required 1 0 0 0 0",
                  ok, bus.pop, bus.rx_valid, bus.pkt_cnt, bus.err_cnt);
      end
      @(negedge clk);
      reset = 1'b1;
      wait_pop(10, cyc, ok);
      @(negedge clk);
      checks++;
      if (!ok || bus.rx_valid !== 1'b1 || bus.rx_payload !== 23'h77 || bus.pkt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL reset_recover: popped=%0d valid=%b payload=%h pkt=%0d, required 1 1 000077 1",
                  ok, bus.rx_valid, bus.rx_payload, bus.pkt_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int stamps[$];
      apply_reset();
      bus.rx_ready = 1'b1;
      for (int i = 0; i < 5; i++) mq.push_back(mk(8'h00, 4'h0, 4'h2, 1'b0, 23'h20 + 23'(i)));
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (bus.pop === 1'b1) stamps.push_back(c);
      end
      checks++;
      if (stamps.size() != 5 || bus.pkt_cnt !== 16'd5) begin
         errors++;
         $display("FAIL b2b_count: pops=%0d pkt=%0d, required 5 5", stamps.size(), bus.pkt_cnt);
      end
      for (int i = 1; i < stamps.size(); i++) begin
         checks++;
         if (stamps[i] - stamps[i-1] != 3) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: gap=%0d, required 3", i, stamps[i] - stamps[i-1]);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      total_pops = 0;
      reset = 1'b0;
      bus.rx_ready = 1'b0;
      test_reset();
      @(negedge clk);
      reset = 1'b1;
      test_accept();
      test_reject();
      test_broadcast();
      test_backpressure();
      test_reset_in_pop();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
